// File: rtl/control_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | control_pkg                                                          |
// | Shared encodings for the multicycle RV32I+Zicsr controller: FSM      |
// | states, opcodes, ALU operation codes and datapath select values.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package control_pkg;

    // FSM state encodings
    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE   = 4'd6;
    localparam logic [3:0] S_ALU_WB    = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [3:0] S_LINK      = 4'd10;
    localparam logic [3:0] S_CSR       = 4'd11;

    // Major opcodes
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    // ALU operation codes
    localparam logic [4:0] ALU_ADD   = 5'b00000;
    localparam logic [4:0] ALU_SUB   = 5'b00001;
    localparam logic [4:0] ALU_AND   = 5'b00010;
    localparam logic [4:0] ALU_OR    = 5'b00011;
    localparam logic [4:0] ALU_XOR   = 5'b00100;
    localparam logic [4:0] ALU_SLL   = 5'b00101;
    localparam logic [4:0] ALU_SLT   = 5'b00110;
    localparam logic [4:0] ALU_SLTU  = 5'b00111;
    localparam logic [4:0] ALU_SRL   = 5'b01000;
    localparam logic [4:0] ALU_SRA   = 5'b01001;
    localparam logic [4:0] ALU_CSRRW = 5'b10000;
    localparam logic [4:0] ALU_CSRRS = 5'b10001;
    localparam logic [4:0] ALU_CSRRC = 5'b10010;

    // ALU operand A select
    localparam logic [2:0] SRC1_PC    = 3'b000;
    localparam logic [2:0] SRC1_OLDPC = 3'b001;
    localparam logic [2:0] SRC1_RS1   = 3'b010;
    localparam logic [2:0] SRC1_ZERO  = 3'b011;
    localparam logic [2:0] SRC1_ZIMM  = 3'b100;

    // ALU operand B select
    localparam logic [1:0] SRC2_RS2   = 2'b00;
    localparam logic [1:0] SRC2_IMM   = 2'b01;
    localparam logic [1:0] SRC2_FOUR  = 2'b10;
    localparam logic [1:0] SRC2_CSR   = 2'b11;

    // Result bus select
    localparam logic [1:0] RES_ALU_RESULT = 2'b00;
    localparam logic [1:0] RES_ALU_OUT    = 2'b01;
    localparam logic [1:0] RES_MEM_DATA   = 2'b10;
    localparam logic [1:0] RES_CSR_RDATA  = 2'b11;

    // Immediate format select
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    // Branch condition from func_3 and the ALU flags of RS1-RS2.
    // Encodings 010/011 are reserved and report not-taken here; the
    // controller flags them illegal separately.
    function automatic logic branch_taken(input logic [2:0] func_3,
                                          input logic       zero,
                                          input logic       slt,
                                          input logic       sltu);
        logic taken;
        case (func_3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = slt;
            3'b101:  taken = !slt;
            3'b110:  taken = sltu;
            3'b111:  taken = !sltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_decoder                                                          |
// | Combinational map from (opcode, func_3, instr[30]) to the 5-bit ALU  |
// | operation code for register, immediate and CSR instructions.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_decoder
    import control_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] func_3,
    input  logic       func_7_5,
    output logic [4:0] alu_control
);

    // Only OP uses instr[30] to pick SUB; OP-IMM uses it only for SRAI
    logic sub_sel;
    assign sub_sel = (op == OPC_OP) && func_7_5;

    // Operation select by instruction class and function fields
    always_comb begin
        alu_control = ALU_ADD;
        if (op == OPC_OP || op == OPC_OP_IMM) begin
            case (func_3)
                3'b000:  alu_control = sub_sel  ? ALU_SUB : ALU_ADD;
                3'b001:  alu_control = ALU_SLL;
                3'b010:  alu_control = ALU_SLT;
                3'b011:  alu_control = ALU_SLTU;
                3'b100:  alu_control = ALU_XOR;
                3'b101:  alu_control = func_7_5 ? ALU_SRA : ALU_SRL;
                3'b110:  alu_control = ALU_OR;
                default: alu_control = ALU_AND;
            endcase
        end else if (op == OPC_SYSTEM) begin
            case (func_3[1:0])
                2'b01:   alu_control = ALU_CSRRW;
                2'b10:   alu_control = ALU_CSRRS;
                2'b11:   alu_control = ALU_CSRRC;
                default: alu_control = ALU_ADD;
            endcase
        end else if (op == OPC_BRANCH) begin
            alu_control = ALU_SUB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | control_unit                                                         |
// | Multicycle RV32I+Zicsr main controller. Sequences fetch, decode,     |
// | execute, memory and writeback over a shared memory port and drives   |
// | the ALU operation code, datapath selects and write strobes.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module control_unit
    import control_pkg::*;
(
    input  logic       clk,
    input  logic       i_rst,
    input  logic [6:0] i_op,
    input  logic [2:0] i_func_3,
    input  logic       i_func_7_5,
    input  logic       i_zero_flag,
    input  logic       i_slt_flag,
    input  logic       i_sltu_flag,
    input  logic       i_mem_done,
    output logic [4:0] o_alu_control,
    output logic [2:0] o_alu_src_1,
    output logic [1:0] o_alu_src_2,
    output logic [1:0] o_result_src,
    output logic [2:0] o_imm_src,
    output logic       o_pc_write,
    output logic       o_instr_write,
    output logic       o_reg_write,
    output logic       o_csr_write,
    output logic       o_mem_read_req,
    output logic       o_mem_write_req,
    output logic       o_illegal_instr,
    output logic       o_retire
);

    logic [3:0] state;
    logic [3:0] next_state;
    logic [4:0] dec_alu_control;
    logic       is_load;
    logic       branch_illegal;
    logic       csr_illegal;

    assign is_load        = (i_op == OPC_LOAD);
    assign branch_illegal = (i_func_3[2:1] == 2'b01);
    assign csr_illegal    = (i_func_3[1:0] == 2'b00);

    alu_decoder u_alu_decoder (
        .op          (i_op),
        .func_3      (i_func_3),
        .func_7_5    (i_func_7_5),
        .alu_control (dec_alu_control)
    );

    // State register; reset always lands in FETCH
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and output decode; reset overrides everything to idle
    always_comb begin
        next_state      = state;
        o_alu_control   = ALU_ADD;
        o_alu_src_1     = SRC1_PC;
        o_alu_src_2     = SRC2_RS2;
        o_result_src    = RES_ALU_RESULT;
        o_imm_src       = IMM_I;
        o_pc_write      = 1'b0;
        o_instr_write   = 1'b0;
        o_reg_write     = 1'b0;
        o_csr_write     = 1'b0;
        o_mem_read_req  = 1'b0;
        o_mem_write_req = 1'b0;
        o_illegal_instr = 1'b0;
        o_retire        = 1'b0;

        case (state)
            S_FETCH: begin
                // PC+4 is written back the same cycle the instruction lands
                o_mem_read_req = 1'b1;
                o_alu_src_1    = SRC1_PC;
                o_alu_src_2    = SRC2_FOUR;
                o_alu_control  = ALU_ADD;
                if (i_mem_done) begin
                    o_instr_write = 1'b1;
                    o_pc_write    = 1'b1;
                    next_state    = S_DECODE;
                end
            end

            S_DECODE: begin
                // Speculatively compute the branch/JAL target into ALU_OUT
                o_alu_src_1   = SRC1_OLDPC;
                o_alu_src_2   = SRC2_IMM;
                o_imm_src     = (i_op == OPC_JAL) ? IMM_J : IMM_B;
                o_alu_control = ALU_ADD;
                case (i_op)
                    OPC_LOAD, OPC_STORE:
                        next_state = S_MEM_ADDR;
                    OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC:
                        next_state = S_EXECUTE;
                    OPC_BRANCH:
                        next_state = S_BRANCH;
                    OPC_JAL, OPC_JALR:
                        next_state = S_JUMP;
                    OPC_SYSTEM: begin
                        if (i_func_3 != 3'b000) begin
                            next_state = S_CSR;
                        end else begin
                            o_illegal_instr = 1'b1;
                            o_retire        = 1'b1;
                            next_state      = S_FETCH;
                        end
                    end
                    OPC_FENCE: begin
                        o_retire   = 1'b1;
                        next_state = S_FETCH;
                    end
                    default: begin
                        o_illegal_instr = 1'b1;
                        o_retire        = 1'b1;
                        next_state      = S_FETCH;
                    end
                endcase
            end

            S_MEM_ADDR: begin
                o_alu_src_1   = SRC1_RS1;
                o_alu_src_2   = SRC2_IMM;
                o_imm_src     = is_load ? IMM_I : IMM_S;
                o_alu_control = ALU_ADD;
                next_state    = is_load ? S_MEM_READ : S_MEM_WRITE;
            end

            S_MEM_READ: begin
                o_mem_read_req = 1'b1;
                if (i_mem_done) begin
                    next_state = S_MEM_WB;
                end
            end

            S_MEM_WB: begin
                o_reg_write  = 1'b1;
                o_result_src = RES_MEM_DATA;
                o_retire     = 1'b1;
                next_state   = S_FETCH;
            end

            S_MEM_WRITE: begin
                // A store retires in the cycle its write completes
                o_mem_write_req = 1'b1;
                if (i_mem_done) begin
                    o_retire   = 1'b1;
                    next_state = S_FETCH;
                end
            end

            S_EXECUTE: begin
                o_alu_control = dec_alu_control;
                case (i_op)
                    OPC_OP: begin
                        o_alu_src_1 = SRC1_RS1;
                        o_alu_src_2 = SRC2_RS2;
                    end
                    OPC_OP_IMM: begin
                        o_alu_src_1 = SRC1_RS1;
                        o_alu_src_2 = SRC2_IMM;
                        o_imm_src   = IMM_I;
                    end
                    OPC_LUI: begin
                        o_alu_src_1   = SRC1_ZERO;
                        o_alu_src_2   = SRC2_IMM;
                        o_imm_src     = IMM_U;
                        o_alu_control = ALU_ADD;
                    end
                    default: begin
                        o_alu_src_1   = SRC1_OLDPC;
                        o_alu_src_2   = SRC2_IMM;
                        o_imm_src     = IMM_U;
                        o_alu_control = ALU_ADD;
                    end
                endcase
                next_state = S_ALU_WB;
            end

            S_ALU_WB: begin
                o_reg_write  = 1'b1;
                o_result_src = RES_ALU_OUT;
                o_retire     = 1'b1;
                next_state   = S_FETCH;
            end

            S_BRANCH: begin
                // Compare RS1-RS2; the target already sits in ALU_OUT
                o_alu_src_1   = SRC1_RS1;
                o_alu_src_2   = SRC2_RS2;
                o_alu_control = ALU_SUB;
                o_result_src  = RES_ALU_OUT;
                o_retire      = 1'b1;
                next_state    = S_FETCH;
                if (branch_illegal) begin
                    o_illegal_instr = 1'b1;
                end else begin
                    o_pc_write = branch_taken(i_func_3, i_zero_flag,
                                              i_slt_flag, i_sltu_flag);
                end
            end

            S_JUMP: begin
                o_pc_write = 1'b1;
                if (i_op == OPC_JALR) begin
                    o_alu_src_1   = SRC1_RS1;
                    o_alu_src_2   = SRC2_IMM;
                    o_imm_src     = IMM_I;
                    o_alu_control = ALU_ADD;
                    o_result_src  = RES_ALU_RESULT;
                end else begin
                    o_result_src  = RES_ALU_OUT;
                end
                next_state = S_LINK;
            end

            S_LINK: begin
                // Link value is the old PC plus four
                o_alu_src_1   = SRC1_OLDPC;
                o_alu_src_2   = SRC2_FOUR;
                o_alu_control = ALU_ADD;
                o_result_src  = RES_ALU_RESULT;
                o_reg_write   = 1'b1;
                o_retire      = 1'b1;
                next_state    = S_FETCH;
            end

            S_CSR: begin
                o_alu_src_1   = i_func_3[2] ? SRC1_ZIMM : SRC1_RS1;
                o_alu_src_2   = SRC2_CSR;
                o_alu_control = dec_alu_control;
                o_result_src  = RES_CSR_RDATA;
                o_retire      = 1'b1;
                next_state    = S_FETCH;
                if (csr_illegal) begin
                    o_illegal_instr = 1'b1;
                end else begin
                    o_csr_write = 1'b1;
                    o_reg_write = 1'b1;
                end
            end

            default: begin
                next_state = S_FETCH;
            end
        endcase

        if (i_rst) begin
            next_state      = S_FETCH;
            o_alu_control   = ALU_ADD;
            o_alu_src_1     = SRC1_PC;
            o_alu_src_2     = SRC2_RS2;
            o_result_src    = RES_ALU_RESULT;
            o_imm_src       = IMM_I;
            o_pc_write      = 1'b0;
            o_instr_write   = 1'b0;
            o_reg_write     = 1'b0;
            o_csr_write     = 1'b0;
            o_mem_read_req  = 1'b0;
            o_mem_write_req = 1'b0;
            o_illegal_instr = 1'b0;
            o_retire        = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_control_unit                                                      |
// | Directed self-checking bench for the multicycle controller.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] func_3;
    logic       func_7_5;
    logic       zero_flag, slt_flag, sltu_flag;
    logic       mem_done;
    logic [4:0] alu_control;
    logic [2:0] alu_src_1;
    logic [1:0] alu_src_2;
    logic [1:0] result_src;
    logic [2:0] imm_src;
    logic       pc_write, instr_write, reg_write, csr_write;
    logic       mem_read_req, mem_write_req, illegal_instr, retire;

    int errors = 0;
    int checks = 0;

    // Per-cycle trace of one instruction, index 0 = first FETCH cycle
    logic [4:0] ac [40];
    logic [2:0] s1 [40];
    logic [1:0] s2 [40];
    logic [1:0] rs [40];
    logic [2:0] im [40];
    logic       pw [40];
    logic       rw [40];
    logic       cw [40];
    logic       il [40];
    int n_cyc, n_ret, n_rw, n_pw, n_cw, n_ill;

    always #5 clk = ~clk;

    control_unit dut (
        .clk             (clk),
        .i_rst           (rst),
        .i_op            (op),
        .i_func_3        (func_3),
        .i_func_7_5      (func_7_5),
        .i_zero_flag     (zero_flag),
        .i_slt_flag      (slt_flag),
        .i_sltu_flag     (sltu_flag),
        .i_mem_done      (mem_done),
        .o_alu_control   (alu_control),
        .o_alu_src_1     (alu_src_1),
        .o_alu_src_2     (alu_src_2),
        .o_result_src    (result_src),
        .o_imm_src       (imm_src),
        .o_pc_write      (pc_write),
        .o_instr_write   (instr_write),
        .o_reg_write     (reg_write),
        .o_csr_write     (csr_write),
        .o_mem_read_req  (mem_read_req),
        .o_mem_write_req (mem_write_req),
        .o_illegal_instr (illegal_instr),
        .o_retire        (retire)
    );

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Run one instruction from FETCH until retire. Memory answers after
    // the request has been high for fwait (fetch) / mwait (data) cycles.
    task automatic run(input logic [6:0] o, input logic [2:0] f,
                       input logic f7, input int fwait, input int mwait);
        int  wcnt;
        int  lim;
        bit  fin;
        bit  fetched;
        op = o; func_3 = f; func_7_5 = f7;
        wcnt = 0; fin = 0; fetched = 0;
        n_cyc = 0; n_ret = 0; n_rw = 0; n_pw = 0; n_cw = 0; n_ill = 0;
        for (int i = 0; i < 40 && !fin; i++) begin
            mem_done = 1'b0;
            #1;
            if (mem_read_req || mem_write_req) begin
                lim = fetched ? mwait : fwait;
                if (wcnt == lim) begin
                    mem_done = 1'b1;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
            #3;
            ac[i] = alu_control; s1[i] = alu_src_1; s2[i] = alu_src_2;
            rs[i] = result_src;  im[i] = imm_src;   pw[i] = pc_write;
            rw[i] = reg_write;   cw[i] = csr_write; il[i] = illegal_instr;
            if (instr_write) fetched = 1;
            if (pc_write && !instr_write) n_pw++;
            if (reg_write) n_rw++;
            if (csr_write) n_cw++;
            if (illegal_instr) n_ill++;
            if (retire) begin
                n_ret++;
                fin = 1;
                n_cyc = i + 1;
            end
            next_cycle();
        end
        mem_done = 1'b0;
        if (!fin) check_value("timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1; op = '0; func_3 = '0; func_7_5 = 1'b0;
        zero_flag = 1'b0; slt_flag = 1'b0; sltu_flag = 1'b0; mem_done = 1'b0;
        next_cycle();

        // Walk a load into MEM_READ, then reset in the middle of it
        rst = 1'b0; op = 7'b0000011; func_3 = 3'b010; mem_done = 1'b1;
        #4;
        check_value("fetch read_req", mem_read_req, 1);
        check_value("fetch instr_write", instr_write, 1);
        next_cycle();
        mem_done = 1'b0;
        #4;
        check_value("decode imm_src B", imm_src, 3'b010);
        check_value("decode src1 OLDPC", alu_src_1, 3'b001);
        next_cycle();
        #4;
        check_value("load addr src1", alu_src_1, 3'b010);
        check_value("load addr imm I", imm_src, 3'b000);
        next_cycle();
        #4;
        check_value("mem_read req", mem_read_req, 1);
        next_cycle();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #4;
            check_value("reset read_req", mem_read_req, 0);
            check_value("reset strobes",
                        {reg_write, pc_write, retire, instr_write}, 0);
            next_cycle();
        end
        rst = 1'b0;
        #4;
        check_value("post-reset read_req", mem_read_req, 1);
        check_value("post-reset retire", retire, 0);
        next_cycle();

        // ADD x3,x1,x2
        run(7'b0110011, 3'b000, 1'b0, 0, 0);
        check_value("add cycles", n_cyc, 4);
        check_value("add alu", ac[2], 5'b00000);
        check_value("add reg_write c4", rw[3], 1);
        check_value("add result ALU_OUT", rs[3], 2'b01);
        check_value("add retires", n_ret, 1);
        check_value("add reg_write count", n_rw, 1);

        // SUB
        run(7'b0110011, 3'b000, 1'b1, 0, 0);
        check_value("sub alu", ac[2], 5'b00001);

        // OP-IMM 000 with instr[30]=1 stays ADD; SRAI picks SRA
        run(7'b0010011, 3'b000, 1'b1, 0, 0);
        check_value("addi alu", ac[2], 5'b00000);
        check_value("addi src2 IMM", s2[2], 2'b01);
        run(7'b0010011, 3'b101, 1'b1, 0, 0);
        check_value("srai alu", ac[2], 5'b01001);

        // BNE, equal operands: not taken
        zero_flag = 1'b1;
        run(7'b1100011, 3'b001, 1'b0, 0, 0);
        check_value("bne cycles", n_cyc, 3);
        check_value("bne no pc_write", n_pw, 0);
        check_value("bne alu SUB", ac[2], 5'b00001);
        zero_flag = 1'b0;

        // BLTU taken
        sltu_flag = 1'b1;
        run(7'b1100011, 3'b110, 1'b0, 0, 0);
        check_value("bltu pc_write", pw[2], 1);
        check_value("bltu result", rs[2], 2'b01);
        check_value("bltu cycles", n_cyc, 3);
        sltu_flag = 1'b0;

        // Reserved branch func_3 is illegal
        run(7'b1100011, 3'b010, 1'b0, 0, 0);
        check_value("bad branch illegal", n_ill, 1);

        // LW with 4-cycle memory delay on both accesses
        run(7'b0000011, 3'b010, 1'b0, 4, 4);
        check_value("lw cycles", n_cyc, 13);
        check_value("lw reg_write count", n_rw, 1);
        check_value("lw result MEM_DATA", rs[12], 2'b10);

        // SW, zero-wait
        run(7'b0100011, 3'b010, 1'b0, 0, 0);
        check_value("sw cycles", n_cyc, 4);
        check_value("sw imm S", im[2], 3'b001);
        check_value("sw no reg_write", n_rw, 0);

        // JAL and JALR
        run(7'b1101111, 3'b000, 1'b0, 0, 0);
        check_value("jal cycles", n_cyc, 4);
        check_value("jal decode imm J", im[1], 3'b100);
        check_value("jal pc result", {pw[2], rs[2]}, 3'b101);
        check_value("jal link", {rw[3], rs[3], s1[3], s2[3]}, 8'b1_00_001_10);
        run(7'b1100111, 3'b000, 1'b0, 0, 0);
        check_value("jalr jump", {pw[2], rs[2], s1[2]}, 6'b1_00_010);

        // LUI
        run(7'b0110111, 3'b000, 1'b0, 0, 0);
        check_value("lui srcs", {s1[2], s2[2], im[2]}, 8'b011_01_011);

        // CSRRCI
        run(7'b1110011, 3'b111, 1'b0, 0, 0);
        check_value("csrrci cycles", n_cyc, 3);
        check_value("csrrci src1", s1[2], 3'b100);
        check_value("csrrci src2", s2[2], 2'b11);
        check_value("csrrci alu", ac[2], 5'b10010);
        check_value("csrrci writes", {cw[2], rw[2], rs[2]}, 4'b11_11);

        // CSR func_3 100 is illegal
        run(7'b1110011, 3'b100, 1'b0, 0, 0);
        check_value("csr f3=100 illegal", {n_ill, n_cw, n_rw}, {32'd1, 32'd0, 32'd0});

        // FENCE and ECALL-class
        run(7'b0001111, 3'b000, 1'b0, 0, 0);
        check_value("fence cycles", n_cyc, 2);
        check_value("fence not illegal", n_ill, 0);
        run(7'b1110011, 3'b000, 1'b0, 0, 0);
        check_value("system f3=0 illegal", il[1], 1);

        // Unknown opcode
        run(7'b1111111, 3'b000, 1'b0, 0, 0);
        check_value("illegal cycles", n_cyc, 2);
        check_value("illegal pulse", il[1], 1);
        check_value("illegal no writes", n_rw + n_cw + n_pw, 0);
        #2;
        check_value("illegal back to fetch", mem_read_req, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control_unit.md
# control_unit

Multicycle RV32I+Zicsr main controller. It drives the ALU's 5-bit operation code and datapath mux selects, and consumes the ALU's zero/slt/sltu flags to resolve branches. It sequences fetch, decode, execute, memory and writeback over the shared memory port, using a request/done handshake. It sits between the instruction register and the datapath.

## Interface
- No parameters; field widths fixed by RV32I.
- `clk`  in  1  clock; all state changes on rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_op`  in  7  opcode, from the instruction register; stable from DECODE until the next FETCH completes.
- `i_func_3`  in  3  instr[14:12].
- `i_func_7_5`  in  1  instr[30].
- `i_zero_flag`, `i_slt_flag`, `i_sltu_flag`  in  1 each  combinational ALU flags.
- `i_mem_done`  in  1  memory transaction complete this cycle.
- `o_alu_control`  out  5  ADD 00000, SUB 00001, AND 00010, OR 00011, XOR 00100, SLL 00101, SLT 00110, SLTU 00111, SRL 01000, SRA 01001, CSRRW 10000, CSRRS 10001, CSRRC 10010.
- `o_alu_src_1`  out  3  000 PC, 001 OLDPC, 010 RS1, 011 ZERO, 100 ZIMM.
- `o_alu_src_2`  out  2  00 RS2, 01 IMM, 10 FOUR, 11 CSR_RDATA.
- `o_result_src`  out  2  00 ALU_RESULT, 01 ALU_OUT (registered), 10 MEM_DATA, 11 CSR_RDATA.
- `o_imm_src`  out  3  000 I, 001 S, 010 B, 011 U, 100 J.
- `o_pc_write`, `o_instr_write`, `o_reg_write`, `o_csr_write`  out  1  write strobes.
- `o_mem_read_req`, `o_mem_write_req`  out  1  memory requests.
- `o_illegal_instr`  out  1  one-cycle pulse.
- `o_retire`  out  1  one-cycle pulse in an instruction's final cycle.

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, ALU_WB, BRANCH, JUMP, LINK, CSR.
- FETCH: read_req=1, src1=PC, src2=FOUR, ADD. On i_mem_done: instr_write=1, pc_write=1 with result ALU_RESULT, go to DECODE; otherwise hold.
- DECODE: src1=OLDPC, src2=IMM (B, or J for JAL), ADD. Target goes to ALU_OUT. Dispatch on i_op:
  - LOAD 0000011 / STORE 0100011 -> MEM_ADDR.
  - OP 0110011, OP-IMM 0010011, LUI 0110111, AUIPC 0010111 -> EXECUTE.
  - BRANCH 1100011 -> BRANCH.
  - JAL 1101111 / JALR 1100111 -> JUMP.
  - SYSTEM 1110011 with func_3≠000 -> CSR.
  - FENCE 0001111 -> FETCH with retire.
  - Anything else, including SYSTEM func_3=000 -> FETCH with illegal_instr=1 and retire=1.
- MEM_ADDR: RS1+IMM (I for load, S for store). Load goes to MEM_READ, store to MEM_WRITE.
- MEM_READ holds read_req until done, then goes to MEM_WB (reg_write, MEM_DATA, retire).
- MEM_WRITE holds write_req until done, then retire and go to FETCH.
- EXECUTE ALU decode:
  - OP: func_3 000 SUB if f7_5 else ADD; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRA if f7_5 else SRL; 110 OR; 111 AND.
  - OP-IMM: same mapping, src2=IMM(I), except 000 is always ADD.
  - LUI: ZERO+IMM(U). AUIPC: OLDPC+IMM(U).
  - Then ALU_WB: reg_write, ALU_OUT, retire.
- BRANCH: RS1−RS2 SUB. Taken when:
  - BEQ: zero. BNE: !zero.
  - BLT: slt. BGE: !slt.
  - BLTU: sltu. BGEU: !sltu.
  - func_3 010/011 -> illegal.
  - If taken: pc_write with ALU_OUT. Always retire and go to FETCH.
- JUMP: pc_write.
  - JAL: result ALU_OUT.
  - JALR: RS1+IMM(I), ADD, result ALU_RESULT; the datapath clears bit 0.
  - Then LINK: OLDPC+FOUR, reg_write with ALU_RESULT, retire.
- CSR: func_3[1:0] 01 CSRRW, 10 CSRRS, 11 CSRRC, 00 illegal.
  - src1=ZIMM if func_3[2], else RS1; src2=CSR_RDATA.
  - csr_write=1 and reg_write=1 with CSR_RDATA, retire.
- Idle selects 0; all strobes 0 outside the listed states.

## Timing
- Moore outputs except the i_mem_done-qualified strobes (instr_write and pc_write in FETCH) and the flag-qualified branch pc_write.
- Cycles with zero-wait memory:
  - FENCE and illegal: 2.
  - Branch and CSR: 3.
  - ALU ops, store, JAL and JALR: 4.
  - Load: 5.
- Memory done may arrive in the request cycle. The request stays high until done; there is no timeout.
- When i_rst=1, the next state is FETCH and all strobes and requests are forced 0 in that cycle. The first cycle after reset is FETCH with read_req=1.
- Reset mid-transaction abandons it; no retire.

## Structure
- `control_pkg`: state enum, opcode constants, ALU control codes, src/result/imm select encodings.
- Sub-module `alu_decoder`: combinational, (op, func_3, func_7_5) -> alu_control.

## Test plan
- Reset held 3 cycles during MEM_READ -> strobes 0. After release: FETCH with read_req=1 and no retire.
- ADD x3,x1,x2 (op 0110011, f3 000, f7_5 0) with done on the first request -> alu_control 00000 in EXECUTE, reg_write in cycle 4, retire once. With f7_5=1 -> 00001.
- BNE with zero_flag=1 -> no pc_write, retire in cycle 3. BLTU with sltu=1 -> pc_write with result 01.
- LW with done delayed 4 cycles in both FETCH and MEM_READ -> 13 cycles total, reg_write with result 10 once.
- CSRRCI (f3 111) -> src1 100, src2 11, alu_control 10010, csr_write and reg_write in the same cycle.
- Opcode 1111111 -> illegal_instr and retire in cycle 2, back to FETCH, no writes.
